// File: rtl/jam_pkg.sv
// Shared JAM definitions: table geometry, cost width and the
// LOAD/SERVE/DONE state encoding used by the engine and the responder.
package jam_pkg;

  localparam int JAM_N      = 8;
  localparam int JAM_COST_W = 7;
  localparam int JAM_IDX_W  = $clog2(JAM_N);
  localparam int JAM_CYC_W  = 20;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } jam_state_e;

endpackage

// File: rtl/jam_cost_table.sv
// Cost table storage: one synchronous write port for the loader and one
// registered read port. When the read is disabled the output register
// clears, so a disabled or out-of-range read presents zero one cycle later.
module jam_cost_table #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Table contents are deliberately not reset; only the loader writes them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read data selection: table entry when enabled, zero otherwise.
  always_comb begin
    rd_data_d = '0;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  // Read output register gives the fixed one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/jam_cost_responder.sv
// Responder side of the JAM worker/job cost interface: loads the N x N
// cost table, serves Cost for each (W,J) with one cycle of latency, counts
// serve cycles and captures the engine's final result on Valid.
module jam_cost_responder
  import jam_pkg::*;
#(
  parameter int N      = JAM_N,
  parameter int COST_W = JAM_COST_W,
  parameter int CYC_W  = JAM_CYC_W,
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1,
  localparam int ADDR_W = 2 * IDX_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ld_valid,
  input  logic [COST_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic [9:0]        MinCost,
  input  logic [3:0]        MatchCount,
  input  logic              Valid,
  output logic              serving,
  output logic              res_valid,
  output logic [9:0]        res_min_cost,
  output logic [3:0]        res_match_count,
  output logic [CYC_W-1:0]  res_cycles,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N * N - 1);

  jam_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic              res_valid_q, res_valid_d;
  logic [9:0]        res_min_cost_q, res_min_cost_d;
  logic [3:0]        res_match_count_q, res_match_count_d;
  logic [CYC_W-1:0]  res_cycles_q, res_cycles_d;

  logic              ld_fire;
  logic              in_range;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  assign ld_fire = ld_valid && (state_q == LOAD);
  assign rd_addr = ADDR_W'(W) * ADDR_W'(N) + ADDR_W'(J);

  // Range check is only meaningful when N leaves unused index codes.
  generate
    if ((1 << IDX_W) == N) begin : gen_range_full
      assign in_range = 1'b1;
    end else begin : gen_range_check
      assign in_range = (W < IDX_W'(N)) && (J < IDX_W'(N));
    end
  endgenerate

  // Cost stays zero while loading so a partial table is never exposed.
  assign rd_en = (state_q != LOAD) && in_range;

  jam_cost_table #(
    .DEPTH  (N * N),
    .ADDR_W (ADDR_W),
    .DATA_W (COST_W)
  ) u_table (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_en   (ld_fire),
    .wr_addr (idx_q),
    .wr_data (ld_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (Cost)
  );

  // Next-state, load index, serve-cycle count, result capture and error.
  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    err_d             = err_q;
    res_valid_d       = res_valid_q;
    res_min_cost_d    = res_min_cost_q;
    res_match_count_d = res_match_count_q;
    res_cycles_d      = res_cycles_q;
    case (state_q)
      LOAD: begin
        if (ld_fire) begin
          idx_d = idx_q + ADDR_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = SERVE;
          end
        end
        // A result before the table is complete is a protocol violation.
        if (Valid) begin
          err_d = 1'b1;
        end
      end
      SERVE: begin
        // The cycle that samples Valid is itself counted.
        if (res_cycles_q != '1) begin
          res_cycles_d = res_cycles_q + CYC_W'(1);
        end
        if (Valid) begin
          res_valid_d       = 1'b1;
          res_min_cost_d    = MinCost;
          res_match_count_d = MatchCount;
          state_d           = DONE;
        end
        if (ld_valid) begin
          err_d = 1'b1;
        end
      end
      DONE: begin
        if (ld_valid) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q           <= LOAD;
      idx_q             <= '0;
      err_q             <= 1'b0;
      res_valid_q       <= 1'b0;
      res_min_cost_q    <= '0;
      res_match_count_q <= '0;
      res_cycles_q      <= '0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      err_q             <= err_d;
      res_valid_q       <= res_valid_d;
      res_min_cost_q    <= res_min_cost_d;
      res_match_count_q <= res_match_count_d;
      res_cycles_q      <= res_cycles_d;
    end
  end

  assign ld_ready        = (state_q == LOAD);
  assign serving         = (state_q == SERVE);
  assign err             = err_q;
  assign res_valid       = res_valid_q;
  assign res_min_cost    = res_min_cost_q;
  assign res_match_count = res_match_count_q;
  assign res_cycles      = res_cycles_q;

endmodule

// File: tb/tb_jam_cost_responder.sv
// Directed-plus-random bench for jam_cost_responder. Expected costs come
// from a plain array holding what was loaded; expected cycle counts come
// from counting clock edges spent serving.
module tb_jam_cost_responder;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        ld_valid;
  logic [6:0]  ld_data;
  logic        ld_ready;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  Cost;
  logic [9:0]  MinCost;
  logic [3:0]  MatchCount;
  logic        Valid;
  logic        serving;
  logic        res_valid;
  logic [9:0]  res_min_cost;
  logic [3:0]  res_match_count;
  logic [19:0] res_cycles;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int ref_tab [64];
  int m_serving = 0;   // bench's belief that the block is serving
  int serve_cnt = 0;   // edges spent serving

  always #5 clk = ~clk;

  jam_cost_responder dut (
    .CLK             (clk),
    .RST_N           (RST_N),
    .ld_valid        (ld_valid),
    .ld_data         (ld_data),
    .ld_ready        (ld_ready),
    .W               (W),
    .J               (J),
    .Cost            (Cost),
    .MinCost         (MinCost),
    .MatchCount      (MatchCount),
    .Valid           (Valid),
    .serving         (serving),
    .res_valid       (res_valid),
    .res_min_cost    (res_min_cost),
    .res_match_count (res_match_count),
    .res_cycles      (res_cycles),
    .err             (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (m_serving != 0) serve_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int w, input int j, input string tag);
    W = 3'(w);
    J = 3'(j);
    tick();
    check(tag, 32'(Cost), 32'(ref_tab[w * 8 + j]));
    $display("read W=%0d J=%0d Cost=%0d", w, j, Cost);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_serving", 32'(serving), 32'd0);
    check("rst_cost", 32'(Cost), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_res_cycles", 32'(res_cycles), 32'd0);
    m_serving = 0;
    serve_cnt = 0;
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; ld_valid = 1'b0; ld_data = '0; W = '0; J = '0;
    MinCost = '0; MatchCount = '0; Valid = 1'b0;
    #2;
    do_reset();
    check("rst_min_cost", 32'(res_min_cost), 32'd0);
    check("rst_match_count", 32'(res_match_count), 32'd0);

    // Phase 1: identity-like table, ld_valid held for 64 cycles.
    for (int i = 0; i < 64; i++) begin
      ref_tab[i] = ((i / 8) * 10 + (i % 8)) % 128;
      ld_valid = 1'b1;
      ld_data  = 7'(ref_tab[i]);
      check("ld_ready_load", 32'(ld_ready), 32'd1);
      check("serving_load", 32'(serving), 32'd0);
      if (i == 32) check("cost_zero_load", 32'(Cost), 32'd0);
      tick();
      $display("load idx=%0d data=%0d", i, ref_tab[i]);
    end
    ld_valid = 1'b0;
    m_serving = 1;
    check("serving_after_load", 32'(serving), 32'd1);
    check("ld_ready_after_load", 32'(ld_ready), 32'd0);
    check("err_after_load", 32'(err), 32'd0);

    W = 3'd3; J = 3'd5; tick();
    check("cost_3_5", 32'(Cost), 32'd35);
    W = 3'd7; J = 3'd0; tick();
    check("cost_7_0", 32'(Cost), 32'd70);
    for (int k = 0; k < 30; k++) rd($urandom_range(7, 0), $urandom_range(7, 0), "cost_rand_p1");
    while (serve_cnt < 39) rd($urandom_range(7, 0), $urandom_range(7, 0), "cost_fill_p1");

    // Valid held 3 cycles; only the first one captures.
    Valid = 1'b1; MinCost = 10'h0C8; MatchCount = 4'd2;
    rd(6, 2, "cost_valid_cycle");
    m_serving = 0;
    check("res_valid", 32'(res_valid), 32'd1);
    check("res_min_cost", 32'(res_min_cost), 32'd200);
    check("res_match_count", 32'(res_match_count), 32'd2);
    check("res_cycles", 32'(res_cycles), 32'(serve_cnt));
    check("res_cycles_40", 32'(res_cycles), 32'd40);
    check("serving_done", 32'(serving), 32'd0);
    $display("result min=%0d match=%0d cycles=%0d", res_min_cost, res_match_count, res_cycles);
    MinCost = 10'h3FF; MatchCount = 4'hF;
    rd($urandom_range(7, 0), $urandom_range(7, 0), "cost_done_1");
    rd($urandom_range(7, 0), $urandom_range(7, 0), "cost_done_2");
    Valid = 1'b0;
    check("no_recapture_min", 32'(res_min_cost), 32'd200);
    check("no_recapture_match", 32'(res_match_count), 32'd2);
    check("cycles_frozen", 32'(res_cycles), 32'd40);
    check("err_clean_done", 32'(err), 32'd0);
    ld_valid = 1'b1; tick(); ld_valid = 1'b0;
    check("err_ld_in_done", 32'(err), 32'd1);
    check("ld_ready_done", 32'(ld_ready), 32'd0);

    // Phase 2: gapped load with random entries.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      ref_tab[i] = (i == 63) ? 77 : int'($urandom_range(127, 0));
      ld_valid = 1'b1;
      ld_data  = 7'(ref_tab[i]);
      tick();
      ld_valid = 1'b0;
      ld_data  = 7'($urandom_range(127, 0));
      if (i < 63) begin
        tick();
        tick();
      end
      if (i == 62) check("serving_gap_partial", 32'(serving), 32'd0);
    end
    m_serving = 1;
    check("serving_gap", 32'(serving), 32'd1);
    check("err_gap", 32'(err), 32'd0);
    W = 3'd7; J = 3'd7; tick();
    check("cost_7_7", 32'(Cost), 32'd77);
    for (int k = 0; k < 20; k++) rd($urandom_range(7, 0), $urandom_range(7, 0), "cost_rand_p2");

    // Phase 3: Valid during load, then reset at idx 30 and full reload.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (i == 10) begin
        Valid = 1'b1; tick(); Valid = 1'b0;
        check("err_valid_load", 32'(err), 32'd1);
        check("res_valid_load", 32'(res_valid), 32'd0);
      end
      ld_valid = 1'b1;
      ld_data  = 7'($urandom_range(127, 0));
      tick();
    end
    ld_valid = 1'b0;
    check("serving_partial", 32'(serving), 32'd0);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      ref_tab[i] = int'($urandom_range(127, 0));
      ld_valid = 1'b1;
      ld_data  = 7'(ref_tab[i]);
      if (i == 63) check("serving_before_last", 32'(serving), 32'd0);
      tick();
    end
    ld_valid = 1'b0;
    m_serving = 1;
    check("serving_reload", 32'(serving), 32'd1);
    for (int a = 0; a < 64; a++) rd(a / 8, a % 8, "cost_reload");
    Valid = 1'b1;
    MinCost = 10'($urandom_range(1023, 0));
    MatchCount = 4'($urandom_range(15, 0));
    tick();
    m_serving = 0;
    check("res_valid_p3", 32'(res_valid), 32'd1);
    check("res_min_p3", 32'(res_min_cost), 32'(MinCost));
    check("res_match_p3", 32'(res_match_count), 32'(MatchCount));
    check("res_cycles_p3", 32'(res_cycles), 32'(serve_cnt));
    check("err_p3", 32'(err), 32'd0);
    Valid = 1'b0;
    $display("result min=%0d match=%0d cycles=%0d", res_min_cost, res_match_count, res_cycles);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
